alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the single-cycle RV32 ALU. Executes the RV32I/RV64I integer operations with one-cycle registered latency and, when compiled in, the M-extension multiply/divide operations iteratively over XLEN cycles. Sits between decode/issue and writeback in the execute stage, with valid/ready on both sides so the pipeline stalls naturally on long operations.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64. Shift amount width SHW = $clog2(XLEN) is derived, not a parameter.
- clk_w_i  in  1  clock; all state on rising edge.
- rst_w_i_l  in  1  reset; asynchronous, active-low.
- in_valid_w_i_h  in  1  operand/op presented.
- in_ready_w_o_h  out  1  block accepts this cycle.
- op_w_i  in  5  {m_sel, ctrl[3:0]}.
- a_data_w_i  in  XLEN  operand A.
- b_data_w_i  in  XLEN  operand B.
- flush_w_i_h  in  1  synchronous abort of any in-flight op.
- out_valid_w_o_h  out  1  result available.
- out_ready_w_i_h  in  1  consumer takes result.
- alu_res_w_o  out  XLEN  result.
- zero_w_o_h  out  1  alu_res_w_o == 0.

## Operation
- m_sel=0, ctrl: 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA; shifts use b[SHW-1:0]; SLT/SLTU produce 0 or 1 zero-extended.
- m_sel=1, ctrl: 0000 MUL (low XLEN), 0001 MULH (s×s), 0010 MULHSU (s×u), 0011 MULHU, 0100 DIV, 0101 DIVU, 0110 REM, 0111 REMU.
- Undefined encodings: accepted, result 0, latency 1.
- FSM states IDLE, BUSY, DONE. Accept = in_valid && in_ready. Single-cycle op: IDLE→DONE. Iterative op: IDLE→BUSY, BUSY counts XLEN iterations then →DONE. DONE→IDLE on out_ready unless a new op is accepted same cycle (then →DONE or →BUSY).
- in_ready_w_o_h = (IDLE) || (DONE && out_ready_w_i_h).
- Multiply: shift-add on |A|,|B| per signedness, 2·XLEN product, sign fixed at end.
- Divide: restoring, on magnitudes; quotient negated if signs differ, remainder takes dividend sign.
- Divide by zero: quotient all-ones, remainder = A. Signed overflow (A = -2^(XLEN-1), B = -1): quotient = A, remainder 0. Both resolve with latency 1, bypassing BUSY.
- flush_w_i_h: next state IDLE, out_valid low, result discarded; flush has priority over accept in the same cycle.
- Result and zero flag held stable while out_valid high and out_ready low.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, alu_res 0, zero 1, iteration counter 0.
- Single-cycle ops and special-case divides: accepted cycle N, out_valid at N+1.
- Iterative mul/div: accepted cycle N, out_valid at N+1+XLEN (N+33 for XLEN=32).
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- Reset asserted mid-BUSY: immediate return to reset values; no partial result emitted.
- Operands captured at accept; input changes afterwards have no effect.

## Configuration
- ALU_M_EXT_EN defined: M-extension ops and the iterative datapath present.
- Not defined: m_sel=1 encodings treated as undefined (result 0, latency 1); BUSY state unreachable and no iterative hardware synthesised.

## Structure
- alu_pkg: op encoding localparams (ctrl codes, m_sel), FSM state typedef, special-case result helpers.
- Sub-module alu_muldiv_iter: iterative shift-add/restoring datapath with start/done, owning the counter and 2·XLEN accumulator; instantiated only under ALU_M_EXT_EN.

## Test plan
- Reset, then ADD a=0x7FFFFFFF b=1 → alu_res=0x80000000, zero=0, out_valid one cycle after accept.
- SRA a=0x80000000 b=0x24 (shamt 4) → 0xF8000000; SUB a=5 b=5 → 0, zero=1.
- MULH a=0xFFFFFFFF b=0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; out_valid exactly 33 cycles after accept.
- DIV a=0x80000000 b=0xFFFFFFFF → 0x80000000 latency 1; DIVU a=7 b=0 → 0xFFFFFFFF; REM a=-7 b=2 → 0xFFFFFFFF.
- Hold out_ready low 5 cycles after a result → result, zero, out_valid stable, in_ready low; release → new op accepted same cycle.
- Assert flush, then separately rst_w_i_l, at BUSY cycle 10 of a DIVU → no out_valid, in_ready high next cycle (flush) / immediately (reset).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state type and divide special-case helper shared by alu_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic       M_SEL_BASE = 1'b0;
    localparam logic       M_SEL_MEXT = 1'b1;

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SLL  = 4'b0001;
    localparam logic [3:0] CTRL_SLT  = 4'b0010;
    localparam logic [3:0] CTRL_SLTU = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_SRL  = 4'b0101;
    localparam logic [3:0] CTRL_OR   = 4'b0110;
    localparam logic [3:0] CTRL_AND  = 4'b0111;
    localparam logic [3:0] CTRL_SUB  = 4'b1000;
    localparam logic [3:0] CTRL_SRA  = 4'b1101;

    localparam logic [3:0] CTRL_MUL    = 4'b0000;
    localparam logic [3:0] CTRL_MULH   = 4'b0001;
    localparam logic [3:0] CTRL_MULHSU = 4'b0010;
    localparam logic [3:0] CTRL_MULHU  = 4'b0011;
    localparam logic [3:0] CTRL_DIV    = 4'b0100;
    localparam logic [3:0] CTRL_DIVU   = 4'b0101;
    localparam logic [3:0] CTRL_REM    = 4'b0110;
    localparam logic [3:0] CTRL_REMU   = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Divide-by-zero and signed-overflow results; callers keep the low XLEN bits.
    function automatic logic [63:0] div_special(input logic rem_op, input logic div_zero,
                                                input logic [63:0] dividend);
        logic [63:0] r;
        if (rem_op) r = div_zero ? dividend : 64'd0;
        else        r = div_zero ? {64{1'b1}} : dividend;
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiplier / restoring divider on operand magnitudes.
// Latency: XLEN cycles from start_vld to done_vld; one iteration per cycle.
// Backpressure: none; caller starts only when idle and must register res_dat on done_vld.
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            core_clk,
    input  logic            arst_n,
    input  logic            start_vld,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a_dat,
    input  logic [XLEN-1:0] b_dat,
    output logic            done_vld,
    output logic [XLEN-1:0] res_dat
);
    localparam int CW = $clog2(XLEN);

    logic              active_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   divisor_q;
    logic              is_div_q;
    logic              neg_q;
    logic              sel_hi_q;

    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   div_part;
    logic [XLEN-1:0]   div_fix;

    // op[2] selects divide; MUL low half is sign-agnostic so it runs unsigned.
    assign is_div = op[2];
    assign sgn_a  = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign sgn_b  = is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign a_neg  = sgn_a & a_dat[XLEN-1];
    assign b_neg  = sgn_b & b_dat[XLEN-1];
    assign mag_a  = a_neg ? -a_dat : a_dat;
    assign mag_b  = b_neg ? -b_dat : b_dat;

    // Accumulator: upper half is partial product / remainder, lower half multiplier / quotient.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, divisor_q};

    always_comb begin
        acc_nxt = acc_q;
        if (!is_div_q)
            acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_nxt = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            acc_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    assign prod_fix = neg_q ? -acc_nxt : acc_nxt;
    assign div_part = sel_hi_q ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    assign div_fix  = neg_q ? -div_part : div_part;
    assign res_dat  = is_div_q ? div_fix
                    : (sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);
    assign done_vld = active_q && (cnt_q == CW'(XLEN - 1));

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            divisor_q <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            sel_hi_q  <= 1'b0;
        end else if (flush) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start_vld) begin
            active_q  <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= {{XLEN{1'b0}}, mag_a};
            divisor_q <= mag_b;
            is_div_q  <= is_div;
            // Remainder follows the dividend sign; quotient and product follow sign xor.
            neg_q     <= (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
            sel_hi_q  <= is_div ? op[1] : (op[1:0] != 2'b00);
        end else if (active_q) begin
            acc_q <= acc_nxt;
            if (done_vld) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I/RV64I ALU; M-extension mul/div compiled in only with ALU_M_EXT_EN.
// Latency: 1 cycle for base ops, undefined ops and div special cases; 1+XLEN for iterative mul/div.
// Backpressure: result held while out_ready is low; in_ready only when idle or the result is leaving.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_w_i,
    input  logic            rst_w_i_l,
    input  logic            in_valid_w_i_h,
    output logic            in_ready_w_o_h,
    input  logic [4:0]      op_w_i,
    input  logic [XLEN-1:0] a_data_w_i,
    input  logic [XLEN-1:0] b_data_w_i,
    input  logic            flush_w_i_h,
    output logic            out_valid_w_o_h,
    input  logic            out_ready_w_i_h,
    output logic [XLEN-1:0] alu_res_w_o,
    output logic            zero_w_o_h
);
    localparam int SHW = $clog2(XLEN);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] single_res;
    logic            accept;
    logic            m_sel;
    logic [3:0]      ctrl;
    logic [SHW-1:0]  shamt;
    logic            is_iter;
    logic            iter_done;

    assign m_sel = op_w_i[4];
    assign ctrl  = op_w_i[3:0];
    assign shamt = b_data_w_i[SHW-1:0];

    assign in_ready_w_o_h  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready_w_i_h);
    assign accept          = in_valid_w_i_h && in_ready_w_o_h && !flush_w_i_h;
    assign out_valid_w_o_h = (state_q == ST_DONE);
    assign alu_res_w_o     = res_q;
    assign zero_w_o_h      = (res_q == '0);

`ifdef ALU_M_EXT_EN
    logic [XLEN-1:0] iter_res;
    logic [63:0]     special_res;
    logic            div_zero;
    logic            div_ovf;

    assign div_zero    = (b_data_w_i == '0);
    assign div_ovf     = (a_data_w_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_data_w_i);
    assign special_res = div_special(ctrl[1], div_zero, 64'(a_data_w_i));

    alu_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .core_clk  (clk_w_i),
        .arst_n    (rst_w_i_l),
        .start_vld (accept && is_iter),
        .flush     (flush_w_i_h),
        .op        (ctrl[2:0]),
        .a_dat     (a_data_w_i),
        .b_dat     (b_data_w_i),
        .done_vld  (iter_done),
        .res_dat   (iter_res)
    );
`else
    assign iter_done = 1'b0;
`endif

    always_comb begin
        single_res = '0;
        is_iter    = 1'b0;
        if (m_sel == M_SEL_BASE) begin
            case (ctrl)
                CTRL_ADD:  single_res = a_data_w_i + b_data_w_i;
                CTRL_SUB:  single_res = a_data_w_i - b_data_w_i;
                CTRL_SLL:  single_res = a_data_w_i << shamt;
                CTRL_SRL:  single_res = a_data_w_i >> shamt;
                CTRL_SRA:  single_res = $signed(a_data_w_i) >>> shamt;
                CTRL_SLT:  single_res = {{(XLEN-1){1'b0}}, $signed(a_data_w_i) < $signed(b_data_w_i)};
                CTRL_SLTU: single_res = {{(XLEN-1){1'b0}}, a_data_w_i < b_data_w_i};
                CTRL_XOR:  single_res = a_data_w_i ^ b_data_w_i;
                CTRL_OR:   single_res = a_data_w_i | b_data_w_i;
                CTRL_AND:  single_res = a_data_w_i & b_data_w_i;
                default:   single_res = '0;
            endcase
        end
`ifdef ALU_M_EXT_EN
        else if (!ctrl[3]) begin
            // Divide by zero and signed overflow resolve immediately without iterating.
            if (ctrl[2] && (div_zero || (!ctrl[0] && div_ovf)))
                single_res = special_res[XLEN-1:0];
            else
                is_iter = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_d = ST_DONE;
            ST_DONE: begin
                if (accept)               state_d = is_iter ? ST_BUSY : ST_DONE;
                else if (out_ready_w_i_h) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_w_i_h) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
        if (!rst_w_i_l) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept && !is_iter)
                res_q <= single_res;
`ifdef ALU_M_EXT_EN
            else if (iter_done && !flush_w_i_h)
                res_q <= iter_res;
`endif
        end
    end

endmodule
